// File: rtl/demux_reg_n_if.sv
// Valid/ready bus bundle for demux_reg_n: one input stream, NCH output channels,
// error pulse and per-channel transfer counts.
interface demux_reg_n_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
);
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_bcast;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic                 err_sel;
    logic [NCH*CNTW-1:0]  xfer_cnt;

    // Producer/consumer side of the bus
    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_sel, xfer_cnt
    );

    // Demultiplexer side of the bus
    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_sel, xfer_cnt
    );
endinterface

// File: rtl/demux_reg_n.sv
// Registered 1:N demultiplexer with unicast/broadcast routing and a one-entry
// holding register per channel. Define DEMUX_REG_N_CNT_EN to build drain counters.
module demux_reg_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    demux_reg_n_if.slave    bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [NCH-1:0]       state_full;
    logic [NCH-1:0]       free;
    logic [NCH-1:0]       sel_hit;
    logic [NCH-1:0]       load;
    logic [NCH-1:0]       drain;
    logic                 sel_ok;
    logic                 in_ready_c;
    logic                 accept;
    logic                 err_sel_reg;
    logic [NCH*WIDTH-1:0] out_data_vec;
    logic [NCH*CNTW-1:0]  cnt_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [SELW-1:0] IDX = SELW'(gi);

            logic [0:0]       state_reg;
            logic [WIDTH-1:0] data_reg;

            assign sel_hit[gi]    = (bus.in_sel == IDX);
            assign state_full[gi] = (state_reg == ST_FULL);
            // A full channel is still free if its consumer takes the beat this edge
            assign free[gi]       = !state_full[gi] || bus.out_ready[gi];
            assign drain[gi]      = state_full[gi] && bus.out_ready[gi];
            assign load[gi]       = accept && (bus.in_bcast || sel_hit[gi]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= ST_EMPTY;
                    data_reg  <= '0;
                end else if (load[gi]) begin
                    state_reg <= ST_FULL;
                    data_reg  <= bus.in_data;
                end else if (drain[gi]) begin
                    state_reg <= ST_EMPTY;
                end
            end

            assign out_data_vec[gi*WIDTH +: WIDTH] = data_reg;

`ifdef DEMUX_REG_N_CNT_EN
            logic [CNTW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (drain[gi]) begin
                    cnt_reg <= cnt_reg + CNTW'(1);
                end
            end

            assign cnt_vec[gi*CNTW +: CNTW] = cnt_reg;
`else
            assign cnt_vec[gi*CNTW +: CNTW] = '0;
`endif
        end
    endgenerate

    // No channel matches when the select is out of range; such beats are sunk
    assign sel_ok     = |sel_hit;
    assign in_ready_c = bus.in_bcast ? &free
                      : (sel_ok ? |(sel_hit & free) : 1'b1);
    assign accept     = bus.in_valid && in_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel_reg <= 1'b0;
        end else begin
            err_sel_reg <= accept && !bus.in_bcast && !sel_ok;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = state_full;
    assign bus.out_data  = out_data_vec;
    assign bus.err_sel   = err_sel_reg;
    assign bus.xfer_cnt  = cnt_vec;
endmodule

// File: tb/tb_demux_reg_n.sv
// Randomised and directed bench for demux_reg_n (NCH=3 so out-of-range selects
// are reachable), checked against a per-channel slot model.
module tb_demux_reg_n;
    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int SELW  = 2;
    localparam int CNTW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_reg_n_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .CNTW(CNTW)) bus ();

    demux_reg_n #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one slot per channel plus a drain tally
    bit             m_full [NCH];
    logic [7:0]     m_data [NCH];
    int             m_drains [NCH];
    bit             m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_full[i]   = 1'b0;
            m_data[i]   = 8'h00;
            m_drains[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [NCH-1:0]       exp_valid;
        logic [NCH*WIDTH-1:0] exp_data;
        logic [NCH*CNTW-1:0]  exp_cnt;
        exp_valid = '0;
        exp_data  = '0;
        exp_cnt   = '0;
        for (int i = 0; i < NCH; i++) begin
            exp_valid[i] = m_full[i];
            exp_data[i*WIDTH +: WIDTH] = m_data[i];
`ifdef DEMUX_REG_N_CNT_EN
            exp_cnt[i*CNTW +: CNTW] = CNTW'(m_drains[i] % (1 << CNTW));
`endif
        end
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
        check({tag, ".out_data"},  64'(bus.out_data),  64'(exp_data));
        check({tag, ".err_sel"},   64'(bus.err_sel),   64'(m_err));
        check({tag, ".xfer_cnt"},  64'(bus.xfer_cnt),  64'(exp_cnt));
    endtask

    // One clock of traffic: check state, drive inputs, check in_ready, advance model
    task automatic step(input logic v, input logic [SELW-1:0] s, input logic b,
                        input logic [7:0] d, input logic [NCH-1:0] r);
        bit exp_ready;
        bit acc;
        @(negedge clk);
        check_outputs("state");
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_bcast  = b;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        if (b) begin
            exp_ready = 1'b1;
            for (int i = 0; i < NCH; i++)
                if (m_full[i] && !r[i]) exp_ready = 1'b0;
        end else if (int'(s) < NCH) begin
            exp_ready = !m_full[s] || r[s];
        end else begin
            exp_ready = 1'b1;
        end
        check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        acc = v && exp_ready;
        if (acc)
            $display("beat bcast=%0d sel=%0d data=%02h ready=%b", b, s, d, r);
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            bit drained;
            drained = m_full[i] && r[i];
            if (drained) m_drains[i]++;
            if (acc && (b || int'(s) == i)) begin
                m_full[i] = 1'b1;
                m_data[i] = d;
            end else if (drained) begin
                m_full[i] = 1'b0;
            end
        end
        m_err = acc && !b && (int'(s) >= NCH);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_bcast  = 1'b1;
        bus.out_ready = '1;
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs("async_rst");
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        check_outputs("in_rst");
        rst = 1'b0;
        bus.in_valid = 1'b0;
        $display("reset pulse applied");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_bcast  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        model_clear();
        #1;
        check_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset, then unicast A5 to ch2 and let it drain
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);
        step(1'b1, 2'd2, 1'b0, 8'hA5, 3'b111);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);

        // Back-pressure on ch1: 22 waits, then drains-and-loads on one edge
        step(1'b1, 2'd1, 1'b0, 8'h11, 3'b101);
        step(1'b1, 2'd1, 1'b0, 8'h22, 3'b101);
        step(1'b1, 2'd1, 1'b0, 8'h22, 3'b101);
        step(1'b1, 2'd1, 1'b0, 8'h22, 3'b111);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);

        // Broadcast blocked by the stalled last channel, then released
        step(1'b1, 2'd2, 1'b0, 8'h55, 3'b011);
        step(1'b1, 2'd0, 1'b1, 8'h3C, 3'b011);
        step(1'b1, 2'd0, 1'b1, 8'h3C, 3'b111);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b000);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);

        // Out-of-range selects, single and back-to-back, and idle with bad select
        step(1'b1, 2'd3, 1'b0, 8'h77, 3'b111);
        step(1'b0, 2'd3, 1'b0, 8'h00, 3'b111);
        step(1'b1, 2'd3, 1'b0, 8'h78, 3'b000);
        step(1'b1, 2'd3, 1'b0, 8'h79, 3'b000);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);

        // 17 back-to-back beats to ch0 so its counter wraps
        for (int i = 0; i < 17; i++)
            step(1'b1, 2'd0, 1'b0, 8'(i + 8'h80), 3'b111);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);
        step(1'b1, 2'd1, 1'b0, 8'hE1, 3'b000);
        reset_mid();
        step(1'b1, 2'd1, 1'b0, 8'hF0, 3'b000);
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b111);

        // Random traffic with one reset in the middle
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) reset_mid();
            step($urandom_range(0, 3) != 0,
                 SELW'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0,
                 8'($urandom),
                 NCH'($urandom | $urandom));
        end
        step(1'b0, 2'd0, 1'b0, 8'h00, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/demux_reg_n.md
Name: demux_reg_n

Overview:
- Parametrised, registered 1:N demultiplexer.
- Routes one input stream to one of NCH output channels, or to all of them in broadcast mode.
- Each channel has a one-entry holding register; both sides use a valid/ready handshake.
- Successor to the combinational 1:2 demux; used wherever a single producer feeds several consumers with independent back-pressure.

Parameters:
- WIDTH, 8, data width per beat.
- NCH, 4, number of output channels (2..16; need not be a power of 2).
- SELW, 2, select width; must satisfy 2**SELW >= NCH.
- CNTW, 8, width of each per-channel transfer counter (optional feature only).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input beat data.
- in_sel  input  SELW  destination channel index.
- in_bcast  input  1  1 = send the beat to all channels; in_sel is ignored.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat is accepted this cycle when high together with in_valid.
- out_data  output  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  NCH  per-channel valid.
- out_ready  input  NCH  per-channel consumer ready.
- err_sel  output  1  one-cycle pulse: an out-of-range select was dropped.
- xfer_cnt  output  NCH*CNTW  per-channel transfer counts (see Optional Feature).

Behaviour:
- Reset (async, active-high): all holding-register valid bits = 0, data = 0, err_sel = 0, xfer_cnt = 0. Outputs change immediately on reset assertion; no handshake completes while rst = 1.
- Per-channel FSM, two states:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on a drain without a load.
  - FULL -> FULL on a load in the same cycle as a drain.
- Drain: out_valid[i] && out_ready[i] at a rising edge.
- out_valid[i] = FULL[i]; the out_data slice is the holding-register contents.
- While out_valid[i]=1 and out_ready[i]=0, the out_data slice is held stable.
- Channel i is "free" when EMPTY[i] || out_ready[i]. This gives a combinational path out_ready -> in_ready, which is intentional and gives full throughput.
- in_ready:
  - in_bcast=1: AND of free over all channels.
  - in_bcast=0 and in_sel < NCH: free[in_sel].
  - in_bcast=0 and in_sel >= NCH: 1.
- Accept = in_valid && in_ready.
  - Unicast: loads in_data into channel in_sel.
  - Broadcast: loads in_data into every channel in the same edge.
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k, i.e. one cycle.
- Non-selected channels keep their state and data untouched.
- Out-of-range select (in_bcast=0, in_sel >= NCH, accepted): the beat is dropped, no channel changes, err_sel = 1 for exactly the following cycle. Back-to-back bad beats keep err_sel high.
- Back-to-back unicast beats to the same channel sustain one beat per cycle while out_ready stays 1.
- in_valid=0: no load, regardless of in_sel and in_bcast.
- Reset mid-operation: all held beats are discarded and nothing is emitted. The first beat after reset deassertion is accepted normally.

Optional Feature:
- Macro: DEMUX_REG_N_CNT_EN.
- Defined:
  - Each channel has a CNTW-bit counter that increments on every drain handshake of that channel.
  - Counters wrap from 2**CNTW-1 to 0.
  - Counters clear on reset.
  - A broadcast beat counts once per channel, when that channel drains.
- Not defined: no counters are built; xfer_cnt is tied to 0, so the port list stays identical.

Test Plan:
- Reset then idle, NCH=4 -> out_valid=4'b0000, in_ready=1, err_sel=0, out_data=0.
- Unicast in_sel=2, in_data=8'hA5, out_ready=4'b1111 -> after one edge out_valid=4'b0100, channel 2 data = A5; empty next cycle if no new beat.
- Back-pressure: out_ready[1]=0, send 8'h11 then 8'h22 to ch1 -> ch1 holds 11, in_ready=0 for ch1. Raise out_ready[1] -> 11 drains, 22 loads on the same edge, out_valid[1] stays 1.
- Broadcast 8'h3C with ch3 FULL and out_ready[3]=0 -> in_ready=0, no channel loads. Release ch3 -> all four channels show 3C one cycle later.
- NCH=3, SELW=2, in_sel=3, in_valid=1 -> in_ready=1, all out_valid unchanged, err_sel=1 for exactly one cycle.
- DEMUX_REG_N_CNT_EN, CNTW=4, 17 drains on ch0 -> xfer_cnt ch0 = 1 (wrapped), other channels 0. Assert rst mid-stream -> all counters and valids return to 0 immediately.
